proc_core_param: RTL and testbench
==================================

Name: proc_core_param

Overview:
- Parametrised successor to the 9-bit multicycle processor: same Run/Done/DataIn handshake and T-step control, generalised in data width and register count.
- Adds an ALU with AND/XOR, Zero/Carry flags, conditional move (mvnz), reserved-opcode trap, and an observable bus.
- Top-level execution core of the processor subsystem. Instructions arrive on DIN from the instruction source; results are visible on BusWires.

Parameters:
- W, 9, datapath and instruction width in bits.
- NREG, 8, number of general registers, power of 2, ≥2; RB = log2(NREG).
- Elaboration error if W < 3+2*RB.

Ports:
- clock  in  1  rising-edge clock
- aReset  in  1  asynchronous, active-high reset
- DIN  in  W  instruction word in T0; immediate operand in T1 (mvi)
- Run  in  1  start request, sampled only in T0
- Done  out  1  high during the final T-step of every instruction
- BusWires  out  W  internal bus value (0 when undriven)
- Zero  out  1  flag: last ALU result == 0
- Carry  out  1  flag: ALU carry-out
- Illegal  out  1  one-cycle pulse when reserved opcode 111 is executed

Behaviour:
- Reset (async, aReset=1): step←T0; IR, A, G, all R[i], Zero, Carry ← 0. Done=0, Illegal=0, BusWires=0. Reset mid-instruction aborts it; no partial write survives.
- IR fields: op=IR[W-1:W-3]; Rx=next RB bits; Ry=next RB bits below Rx. Remaining low bits are ignored.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 xor, 110 mvnz, 111 reserved.
- Step FSM: T0→T1→T2→T3→T0. Any instruction returns to T0 immediately after its Done cycle.
- T0 (idle/fetch): if Run=1 at the edge, IR←DIN and step→T1; otherwise stay in T0. Run is ignored in T1–T3.
- mv: T1 bus=R[Ry], R[Rx]←bus, Done=1.
- mvi: T1 bus=DIN, R[Rx]←bus, Done=1.
- mvnz: T1 Done=1. If Zero=0: bus=R[Ry], R[Rx]←bus. If Zero=1: no write, bus=0.
- reserved (111): T1 Done=1, Illegal=1, no state change.
- add/sub/and/xor:
  - T1: bus=R[Rx], A←bus.
  - T2: bus=R[Ry]; G←A op bus; Zero/Carry updated.
  - T3: bus=G, R[Rx]←G, Done=1.
- Latency: mv, mvi, mvnz and reserved take 2 cycles including fetch; ALU ops take 4.
- Arithmetic is modulo 2^W.
  - add: Carry = carry-out of A+B.
  - sub: computed as A+~B+1; Carry = carry-out (1 means no borrow).
  - and/xor: Carry←0.
  - Zero←(result==0) for all four ALU ops.
  - Flags change only in T2 of ALU ops.
- Rx==Ry is legal. Example: sub R0,R0 gives 0, Zero=1, Carry=1.
- Done and Illegal are decoded combinationally from registered state; no glitch requirement beyond synchronous sampling.
- Bus mux is one-hot with a single driver per step; all-off yields 0.

Decomposition:
- Package proc_pkg: opcode constants (OP_MV … OP_RSVD), T-step encoding (T0..T3), field-position functions derived from W and RB.
- Sub-module proc_alu: combinational; inputs A, B, op; outputs result, carry, zero.
- FSM, IR, register file and bus mux stay in proc_core_param.

Test Plan (W=9, NREG=8; encoding op_Rx_Ry):
- Reset, hold Run=0 for 5 cycles → step stays T0, Done=0, BusWires=0, all registers 0.
- mvi R0: DIN=001_000_000 with Run; next cycle DIN=0x005 → Done=1 in T1, BusWires=5, R0=5.
- mv R1,R0 (000_001_000), then add R0,R1 (010_000_001) → R0=10; Done only in T3; Zero=0, Carry=0.
- sub R2,R2 after mvi R2,#0x1FF → R2=0, Zero=1, Carry=1; then mvnz R3,R0 → R3 unchanged (0).
- mvi R4,#0x1FF; mvi R5,#1; add R4,R5 → R4=0, Carry=1, Zero=1. Then xor R5,R5 → Carry=0, Zero=1.
- Opcode 111 → Illegal and Done pulse for 1 cycle, no register change. Separately, assert aReset during T2 of an add → T0 on the next clock, destination register still 0.

Source files
------------

// File: rtl/proc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : proc_pkg
// Purpose  : Opcode constants, T-step encoding and instruction field helpers
//            shared by the parametrised multicycle core.
// Revision : 1.0 - initial release
// ============================================================================
package proc_pkg;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_XOR  = 3'b101;
    localparam logic [2:0] OP_MVNZ = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    // Fields are packed from the MSB down: op (3 bits), Rx, Ry.
    function automatic int op_lsb(input int w);
        return w - 3;
    endfunction

    function automatic int rx_lsb(input int w, input int rb);
        return w - 3 - rb;
    endfunction

    function automatic int ry_lsb(input int w, input int rb);
        return w - 3 - 2 * rb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/proc_core_param_if.sv
`default_nettype none
// ============================================================================
// Module   : proc_core_param_if
// Purpose  : Instruction handshake and observable bus of the execution core.
// Revision : 1.0 - initial release
// ============================================================================
interface proc_core_param_if #(
    parameter int W = 9
);
    logic [W-1:0] DIN;
    logic         Run;
    logic         Done;
    logic [W-1:0] BusWires;
    logic         Zero;
    logic         Carry;
    logic         Illegal;

    modport master (
        output DIN, Run,
        input  Done, BusWires, Zero, Carry, Illegal
    );

    modport slave (
        input  DIN, Run,
        output Done, BusWires, Zero, Carry, Illegal
    );
endinterface
`default_nettype wire

// File: rtl/proc_core_param_alu.sv
`default_nettype none
// ============================================================================
// Module   : proc_alu
// Purpose  : Combinational add/sub/and/xor with carry and zero outputs.
// Revision : 1.0 - initial release
// ============================================================================
module proc_alu
    import proc_pkg::*;
#(
    parameter int W = 9
) (
    input  wire logic [W-1:0] i_a,
    input  wire logic [W-1:0] i_b,
    input  wire logic [2:0]   i_op,
    output logic      [W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero
);

    logic [W:0] w_sum;

    // Subtraction is A + ~B + 1, so carry-out set means no borrow.
    always_comb begin
        w_sum    = '0;
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_sum[W-1:0];
                o_carry  = w_sum[W];
            end
            OP_SUB: begin
                w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, 1'b1};
                o_result = w_sum[W-1:0];
                o_carry  = w_sum[W];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            default: o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule
`default_nettype wire

// File: rtl/proc_core_param.sv
`default_nettype none
// ============================================================================
// Module   : proc_core_param
// Purpose  : Parametrised multicycle execution core: T-step FSM, IR,
//            register file, one-hot bus mux and flag registers.
// Revision : 1.0 - initial release
// ============================================================================
module proc_core_param
    import proc_pkg::*;
#(
    parameter int W    = 9,
    parameter int NREG = 8
) (
    input  wire logic         clock,
    input  wire logic         aReset,
    proc_core_param_if.slave  bus
);

    localparam int RB        = $clog2(NREG);
    localparam int c_OP_LSB  = op_lsb(W);
    localparam int c_RX_LSB  = rx_lsb(W, RB);
    localparam int c_RY_LSB  = ry_lsb(W, RB);

    generate
        if (W < 3 + 2 * RB) begin : g_width_check
            $error("proc_core_param: W too small for opcode and two register fields");
        end
        if (NREG < 2 || (1 << RB) != NREG) begin : g_nreg_check
            $error("proc_core_param: NREG must be a power of 2 and at least 2");
        end
    endgenerate

    logic [1:0]   r_step;
    logic [1:0]   w_next_step;
    logic [W-1:0] r_ir;
    logic [W-1:0] r_a;
    logic [W-1:0] r_g;
    logic         r_zero;
    logic         r_carry;
    logic [W-1:0] r_regs [NREG];

    logic [2:0]    w_op;
    logic [RB-1:0] w_rx;
    logic [RB-1:0] w_ry;

    logic         w_ir_we, w_a_we, w_g_we, w_rx_we;
    logic         w_sel_din, w_sel_rx, w_sel_ry, w_sel_g;
    logic         w_done, w_illegal;
    logic [W-1:0] w_bus;
    logic [W-1:0] w_alu_result;
    logic         w_alu_carry, w_alu_zero;

    assign w_op = r_ir[c_OP_LSB +: 3];
    assign w_rx = r_ir[c_RX_LSB +: RB];
    assign w_ry = r_ir[c_RY_LSB +: RB];

    always_ff @(posedge clock or posedge aReset) begin
        if (aReset) begin
            r_step <= T0;
        end else begin
            r_step <= w_next_step;
        end
    end

    always_comb begin
        w_next_step = r_step;
        w_ir_we     = 1'b0;
        w_a_we      = 1'b0;
        w_g_we      = 1'b0;
        w_rx_we     = 1'b0;
        w_sel_din   = 1'b0;
        w_sel_rx    = 1'b0;
        w_sel_ry    = 1'b0;
        w_sel_g     = 1'b0;
        w_done      = 1'b0;
        w_illegal   = 1'b0;
        case (r_step)
            T0: begin
                if (bus.Run) begin
                    w_ir_we     = 1'b1;
                    w_next_step = T1;
                end
            end
            T1: begin
                case (w_op)
                    OP_MV: begin
                        w_sel_ry    = 1'b1;
                        w_rx_we     = 1'b1;
                        w_done      = 1'b1;
                        w_next_step = T0;
                    end
                    OP_MVI: begin
                        w_sel_din   = 1'b1;
                        w_rx_we     = 1'b1;
                        w_done      = 1'b1;
                        w_next_step = T0;
                    end
                    OP_MVNZ: begin
                        // With Zero set nothing drives the bus and nothing is written.
                        w_sel_ry    = ~r_zero;
                        w_rx_we     = ~r_zero;
                        w_done      = 1'b1;
                        w_next_step = T0;
                    end
                    OP_RSVD: begin
                        w_done      = 1'b1;
                        w_illegal   = 1'b1;
                        w_next_step = T0;
                    end
                    default: begin
                        w_sel_rx    = 1'b1;
                        w_a_we      = 1'b1;
                        w_next_step = T2;
                    end
                endcase
            end
            T2: begin
                w_sel_ry    = 1'b1;
                w_g_we      = 1'b1;
                w_next_step = T3;
            end
            default: begin
                w_sel_g     = 1'b1;
                w_rx_we     = 1'b1;
                w_done      = 1'b1;
                w_next_step = T0;
            end
        endcase
    end

    assign w_bus = ({W{w_sel_din}} & bus.DIN)
                 | ({W{w_sel_rx}}  & r_regs[w_rx])
                 | ({W{w_sel_ry}}  & r_regs[w_ry])
                 | ({W{w_sel_g}}   & r_g);

    proc_alu #(
        .W (W)
    ) u_alu (
        .i_a      (r_a),
        .i_b      (w_bus),
        .i_op     (w_op),
        .o_result (w_alu_result),
        .o_carry  (w_alu_carry),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clock or posedge aReset) begin
        if (aReset) begin
            r_ir    <= '0;
            r_a     <= '0;
            r_g     <= '0;
            r_zero  <= 1'b0;
            r_carry <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_ir_we) r_ir <= bus.DIN;
            if (w_a_we)  r_a  <= w_bus;
            if (w_g_we) begin
                r_g     <= w_alu_result;
                r_zero  <= w_alu_zero;
                r_carry <= w_alu_carry;
            end
            if (w_rx_we) r_regs[w_rx] <= w_bus;
        end
    end

    assign bus.BusWires = w_bus;
    assign bus.Done     = w_done;
    assign bus.Illegal  = w_illegal;
    assign bus.Zero     = r_zero;
    assign bus.Carry    = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_proc_core_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_core_param
// Purpose  : Directed, table-driven self-checking bench for proc_core_param.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_core_param;

    localparam int W = 9;

    logic clock  = 1'b0;
    logic aReset = 1'b1;

    proc_core_param_if #(.W(W)) bus_if ();

    proc_core_param #(
        .W    (W),
        .NREG (8)
    ) dut (
        .clock  (clock),
        .aReset (aReset),
        .bus    (bus_if.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [8:0] instr;
        logic [8:0] imm;
        logic       run_hold;
        int         lat;
        logic [8:0] bus;
        logic       zero;
        logic       carry;
        logic       ill;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Fetch one instruction, then wait (bounded) for Done and capture outputs.
    task automatic exec(input logic [8:0] instr, input logic [8:0] imm, input logic run_hold,
                        output int lat, output logic [8:0] bus_d, output logic ill_d);
        @(negedge clock);
        bus_if.DIN = instr;
        bus_if.Run = 1'b1;
        @(negedge clock);
        bus_if.Run = run_hold;
        bus_if.DIN = imm;
        #1;
        lat = 2;
        while (bus_if.Done !== 1'b1 && lat < 8) begin
            @(negedge clock);
            #1;
            lat++;
        end
        bus_d = bus_if.BusWires;
        ill_d = bus_if.Illegal;
        bus_if.Run = 1'b0;
        @(negedge clock);
        #1;
        chk($sformatf("i%03h_done_after", instr), {31'd0, bus_if.Done}, 32'd0);
        chk($sformatf("i%03h_ill_after", instr), {31'd0, bus_if.Illegal}, 32'd0);
    endtask

    initial begin
        int         lat;
        logic [8:0] bus_d;
        logic       ill_d;
        logic [2:0] k;

        bus_if.DIN = '0;
        bus_if.Run = 1'b0;

        vecs[0]  = '{9'h040, 9'h005, 1'b0, 2, 9'h005, 1'b0, 1'b0, 1'b0}; // mvi R0,#5
        vecs[1]  = '{9'h008, 9'h000, 1'b0, 2, 9'h005, 1'b0, 1'b0, 1'b0}; // mv R1,R0
        vecs[2]  = '{9'h081, 9'h000, 1'b1, 4, 9'h00A, 1'b0, 1'b0, 1'b0}; // add R0,R1, Run held
        vecs[3]  = '{9'h000, 9'h000, 1'b0, 2, 9'h00A, 1'b0, 1'b0, 1'b0}; // mv R0,R0
        vecs[4]  = '{9'h050, 9'h1FF, 1'b0, 2, 9'h1FF, 1'b0, 1'b0, 1'b0}; // mvi R2,#1FF
        vecs[5]  = '{9'h0D2, 9'h000, 1'b0, 4, 9'h000, 1'b1, 1'b1, 1'b0}; // sub R2,R2
        vecs[6]  = '{9'h198, 9'h000, 1'b0, 2, 9'h000, 1'b1, 1'b1, 1'b0}; // mvnz R3,R0, Zero=1
        vecs[7]  = '{9'h01B, 9'h000, 1'b0, 2, 9'h000, 1'b1, 1'b1, 1'b0}; // mv R3,R3
        vecs[8]  = '{9'h060, 9'h1FF, 1'b0, 2, 9'h1FF, 1'b1, 1'b1, 1'b0}; // mvi R4,#1FF
        vecs[9]  = '{9'h068, 9'h001, 1'b0, 2, 9'h001, 1'b1, 1'b1, 1'b0}; // mvi R5,#1
        vecs[10] = '{9'h0A5, 9'h000, 1'b0, 4, 9'h000, 1'b1, 1'b1, 1'b0}; // add R4,R5
        vecs[11] = '{9'h16D, 9'h000, 1'b0, 4, 9'h000, 1'b1, 1'b0, 1'b0}; // xor R5,R5
        vecs[12] = '{9'h100, 9'h000, 1'b0, 4, 9'h00A, 1'b0, 1'b0, 1'b0}; // and R0,R0
        vecs[13] = '{9'h1B0, 9'h000, 1'b1, 2, 9'h00A, 1'b0, 1'b0, 1'b0}; // mvnz R6,R0, Zero=0
        vecs[14] = '{9'h036, 9'h000, 1'b0, 2, 9'h00A, 1'b0, 1'b0, 1'b0}; // mv R6,R6
        vecs[15] = '{9'h1C8, 9'h000, 1'b0, 2, 9'h000, 1'b0, 1'b0, 1'b1}; // reserved
        vecs[16] = '{9'h009, 9'h000, 1'b0, 2, 9'h005, 1'b0, 1'b0, 1'b0}; // mv R1,R1
        vecs[17] = '{9'h0C8, 9'h000, 1'b0, 4, 9'h1FB, 1'b0, 1'b0, 1'b0}; // sub R1,R0 (borrow)
        vecs[18] = '{9'h141, 9'h000, 1'b0, 4, 9'h1F1, 1'b0, 1'b0, 1'b0}; // xor R0,R1
        vecs[19] = '{9'h089, 9'h000, 1'b0, 4, 9'h1F6, 1'b0, 1'b1, 1'b0}; // add R1,R1

        // Reset state, then idle with Run low.
        @(negedge clock);
        @(negedge clock);
        chk("rst_done",    {31'd0, bus_if.Done},     32'd0);
        chk("rst_bus",     {23'd0, bus_if.BusWires}, 32'd0);
        chk("rst_zero",    {31'd0, bus_if.Zero},     32'd0);
        chk("rst_carry",   {31'd0, bus_if.Carry},    32'd0);
        chk("rst_illegal", {31'd0, bus_if.Illegal},  32'd0);
        aReset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk($sformatf("idle%0d_done", i), {31'd0, bus_if.Done},     32'd0);
            chk($sformatf("idle%0d_bus", i),  {23'd0, bus_if.BusWires}, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            k = 3'(i);
            exec({3'b000, k, k}, 9'h000, 1'b0, lat, bus_d, ill_d);
            chk($sformatf("rst_r%0d", i), {23'd0, bus_d}, 32'd0);
        end

        for (int i = 0; i < 20; i++) begin
            exec(vecs[i].instr, vecs[i].imm, vecs[i].run_hold, lat, bus_d, ill_d);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_bus", i),     {23'd0, bus_d},         {23'd0, vecs[i].bus});
            chk($sformatf("v%0d_zero", i),    {31'd0, bus_if.Zero},   {31'd0, vecs[i].zero});
            chk($sformatf("v%0d_carry", i),   {31'd0, bus_if.Carry},  {31'd0, vecs[i].carry});
            chk($sformatf("v%0d_illegal", i), {31'd0, ill_d},         {31'd0, vecs[i].ill});
        end

        // Abort add R7,R6 with a reset in T2; R7 must stay 0 and R6 is cleared.
        @(negedge clock);
        bus_if.DIN = 9'h0BE;
        bus_if.Run = 1'b1;
        @(negedge clock);
        bus_if.Run = 1'b0;
        #1;
        chk("abort_t1_bus",  {23'd0, bus_if.BusWires}, 32'd0);
        @(negedge clock);
        #1;
        chk("abort_t2_bus",  {23'd0, bus_if.BusWires}, 32'h00A);
        chk("abort_t2_done", {31'd0, bus_if.Done},     32'd0);
        aReset = 1'b1;
        #1;
        chk("abort_rst_bus", {23'd0, bus_if.BusWires}, 32'd0);
        @(negedge clock);
        aReset = 1'b0;
        @(negedge clock);
        chk("abort_idle_done", {31'd0, bus_if.Done}, 32'd0);
        exec(9'h03F, 9'h000, 1'b0, lat, bus_d, ill_d); // mv R7,R7
        chk("abort_r7",     {23'd0, bus_d}, 32'd0);
        chk("abort_r7_lat", 32'(lat),       32'd2);
        exec(9'h036, 9'h000, 1'b0, lat, bus_d, ill_d); // mv R6,R6
        chk("abort_r6",     {23'd0, bus_d},         32'd0);
        chk("abort_zero",   {31'd0, bus_if.Zero},   32'd0);
        chk("abort_carry",  {31'd0, bus_if.Carry},  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
